// File: rtl/fb_pkg.sv
// ============================================================================
//  Module      : fb_pkg
//  Description : Shared framebuffer constants, colour type and queue FSM states.
//                Optional macro FB_CLEAR_EN adds the CLEAR state.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fb_pkg;

    localparam int              FB_WIDTH     = 640;
    localparam int              FB_HEIGHT    = 400;
    localparam int              FB_ADDR_W    = 18;
    localparam logic [17:0]     FB_LAST_ADDR = 18'd255999;

    typedef logic [15:0] colour_t;

`ifdef FB_CLEAR_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1
    } state_t;
`endif

    // y*640 + x as two shifts and an add; row stride is fixed by the SRAM layout.
    function automatic logic [FB_ADDR_W-1:0] fb_linear_addr(
        input logic [9:0] x,
        input logic [9:0] y
    );
        logic [FB_ADDR_W-1:0] w_x;
        logic [FB_ADDR_W-1:0] w_y;
        w_x = {8'd0, x};
        w_y = {8'd0, y};
        return (w_y << 9) + (w_y << 7) + w_x;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fb_sync_fifo.sv
// ============================================================================
//  Module      : fb_sync_fifo
//  Description : Single-clock FIFO with registered full/empty flags and a
//                combinational head read. DEPTH must be a power of two >= 2.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 34
) (
    input  logic                     I_CLK,
    input  logic                     I_RST,
    input  logic                     I_PUSH,
    input  logic [WIDTH-1:0]         I_WDATA,
    input  logic                     I_POP,
    output logic [WIDTH-1:0]         O_RDATA,
    output logic                     O_FULL,
    output logic                     O_EMPTY,
    output logic [$clog2(DEPTH):0]   O_COUNT
);

    localparam int           c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0] c_depth = (c_aw+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_do_push;
    logic             w_do_pop;
    logic [c_aw:0]    w_count_nxt;

    // Push is gated by the pre-edge full flag, so a same-cycle pop never
    // makes room for the push.
    assign w_do_push   = I_PUSH && !r_full;
    assign w_do_pop    = I_POP  && !r_empty;
    assign w_count_nxt = r_count + {{c_aw{1'b0}}, w_do_push} - {{c_aw{1'b0}}, w_do_pop};

    always_ff @(posedge I_CLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= I_WDATA;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_depth);
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign O_RDATA = r_mem[r_rd_ptr];
    assign O_FULL  = r_full;
    assign O_EMPTY = r_empty;
    assign O_COUNT = r_count;

endmodule

`default_nettype wire

// File: rtl/fb_write_queue.sv
// ============================================================================
//  Module      : fb_write_queue
//  Description : Pixel write queue between draw engine and SRAM; drains only
//                while video is off. Macro FB_CLEAR_EN adds a full-screen fill.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_write_queue #(
    parameter int DEPTH     = 16,
    parameter int FB_WIDTH  = 640,
    parameter int FB_HEIGHT = 400
) (
    input  logic        I_CLK,
    input  logic        I_RST,
    input  logic        I_VIDEO_ON,
    input  logic        I_PIX_VALID,
    output logic        O_PIX_READY,
    input  logic [9:0]  I_PIX_X,
    input  logic [9:0]  I_PIX_Y,
    input  logic [15:0] I_PIX_COLOR,
    output logic [17:0] O_GPU_ADDR,
    output logic [15:0] O_GPU_DATA,
    output logic        O_GPU_WRITE,
    output logic        O_GPU_READ,
    output logic        O_EMPTY,
    output logic        O_FULL,
    output logic [15:0] O_DROP_CNT
`ifdef FB_CLEAR_EN
    ,
    input  logic        I_CLEAR_REQ,
    input  logic [15:0] I_CLEAR_COLOR,
    output logic        O_CLEAR_BUSY
`endif
);

    import fb_pkg::*;

    localparam logic [9:0] c_x_lim = 10'(FB_WIDTH);
    localparam logic [9:0] c_y_lim = 10'(FB_HEIGHT);
    localparam int         c_cw    = $clog2(DEPTH) + 1;

    state_t                 r_state;
    logic [FB_ADDR_W-1:0]   r_addr;
    colour_t                r_data;
    logic                   r_write;
    logic [15:0]            r_drop;

    logic                   w_full;
    logic                   w_empty;
    logic [c_cw-1:0]        w_count;
    logic [FB_ADDR_W+15:0]  w_rdata;
    logic                   w_in_range;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_pop;
    logic                   w_last;

`ifdef FB_CLEAR_EN
    logic                   r_clr_pend;
    colour_t                r_clr_color;
    logic [FB_ADDR_W-1:0]   r_clr_addr;

    assign O_PIX_READY  = !w_full && (r_state != CLEAR);
    assign O_CLEAR_BUSY = r_clr_pend || (r_state == CLEAR);
`else
    assign O_PIX_READY  = !w_full;
`endif

    assign w_in_range = (I_PIX_X < c_x_lim) && (I_PIX_Y < c_y_lim);
    assign w_accept   = I_PIX_VALID && O_PIX_READY;
    assign w_push     = w_accept && w_in_range;
    assign w_drop     = w_accept && !w_in_range;

    // Pops are launched from IDLE too, giving the one-cycle accept-to-write path.
    assign w_pop  = ((r_state == IDLE) || (r_state == DRAIN)) && !I_VIDEO_ON && !w_empty;
    assign w_last = (w_count == c_cw'(1)) && !w_push;

    fb_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FB_ADDR_W + 16)
    ) u_fifo (
        .I_CLK   (I_CLK),
        .I_RST   (I_RST),
        .I_PUSH  (w_push),
        .I_WDATA ({fb_linear_addr(I_PIX_X, I_PIX_Y), I_PIX_COLOR}),
        .I_POP   (w_pop),
        .O_RDATA (w_rdata),
        .O_FULL  (w_full),
        .O_EMPTY (w_empty),
        .O_COUNT (w_count)
    );

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_write <= 1'b0;
            r_drop  <= '0;
`ifdef FB_CLEAR_EN
            r_clr_pend  <= 1'b0;
            r_clr_color <= '0;
            r_clr_addr  <= '0;
`endif
        end else begin
            r_write <= 1'b0;

            if (w_drop && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end

            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_addr  <= w_rdata[FB_ADDR_W+15:16];
                        r_data  <= w_rdata[15:0];
                        r_write <= 1'b1;
                        if (!w_last) begin
                            r_state <= DRAIN;
                        end
                    end
`ifdef FB_CLEAR_EN
                    else if (r_clr_pend && w_empty) begin
                        r_state    <= CLEAR;
                        r_clr_pend <= 1'b0;
                        r_clr_addr <= '0;
                    end
`endif
                end
                DRAIN: begin
                    if (w_pop) begin
                        r_addr  <= w_rdata[FB_ADDR_W+15:16];
                        r_data  <= w_rdata[15:0];
                        r_write <= 1'b1;
                        if (w_last) begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
`ifdef FB_CLEAR_EN
                CLEAR: begin
                    // Video-on freezes r_clr_addr so the fill resumes in place.
                    if (!I_VIDEO_ON) begin
                        r_addr  <= r_clr_addr;
                        r_data  <= r_clr_color;
                        r_write <= 1'b1;
                        if (r_clr_addr == FB_LAST_ADDR) begin
                            r_state <= IDLE;
                        end else begin
                            r_clr_addr <= r_clr_addr + 18'd1;
                        end
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase

`ifdef FB_CLEAR_EN
            if (I_CLEAR_REQ && !r_clr_pend && (r_state != CLEAR)) begin
                r_clr_pend  <= 1'b1;
                r_clr_color <= I_CLEAR_COLOR;
            end
`endif
        end
    end

    assign O_GPU_ADDR  = r_addr;
    assign O_GPU_DATA  = r_data;
    assign O_GPU_WRITE = r_write;
    assign O_GPU_READ  = 1'b0;
    assign O_EMPTY     = w_empty;
    assign O_FULL      = w_full;
    assign O_DROP_CNT  = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_fb_write_queue.sv
// ============================================================================
//  Module      : tb_fb_write_queue
//  Description : Directed self-checking bench for fb_write_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fb_write_queue;

    logic        clk;
    logic        rst;
    logic        video_on;
    logic        pix_valid;
    logic        pix_ready;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [15:0] pix_color;
    logic [17:0] gpu_addr;
    logic [15:0] gpu_data;
    logic        gpu_write;
    logic        gpu_read;
    logic        empty;
    logic        full;
    logic [15:0] drop_cnt;
`ifdef FB_CLEAR_EN
    logic        clear_req;
    logic [15:0] clear_color;
    logic        clear_busy;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Write log captured on the falling edge, mid-cycle.
    int          wr_n = 0;
    logic [17:0] log_addr [64];
    logic [15:0] log_data [64];
    int          log_cyc  [64];

    fb_write_queue #(
        .DEPTH     (16),
        .FB_WIDTH  (640),
        .FB_HEIGHT (400)
    ) dut (
        .I_CLK         (clk),
        .I_RST         (rst),
        .I_VIDEO_ON    (video_on),
        .I_PIX_VALID   (pix_valid),
        .O_PIX_READY   (pix_ready),
        .I_PIX_X       (pix_x),
        .I_PIX_Y       (pix_y),
        .I_PIX_COLOR   (pix_color),
        .O_GPU_ADDR    (gpu_addr),
        .O_GPU_DATA    (gpu_data),
        .O_GPU_WRITE   (gpu_write),
        .O_GPU_READ    (gpu_read),
        .O_EMPTY       (empty),
        .O_FULL        (full),
        .O_DROP_CNT    (drop_cnt)
`ifdef FB_CLEAR_EN
        ,
        .I_CLEAR_REQ   (clear_req),
        .I_CLEAR_COLOR (clear_color),
        .O_CLEAR_BUSY  (clear_busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (gpu_write && !rst) begin
            if (wr_n < 64) begin
                log_addr[wr_n] = gpu_addr;
                log_data[wr_n] = gpu_data;
                log_cyc[wr_n]  = cyc;
            end
            wr_n = wr_n + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pix(input logic [9:0] x, input logic [9:0] y, input logic [15:0] c);
        pix_valid = 1'b1;
        pix_x     = x;
        pix_y     = y;
        pix_color = c;
        tick();
        pix_valid = 1'b0;
    endtask

    int base;

    initial begin
        rst       = 1'b1;
        video_on  = 1'b0;
        pix_valid = 1'b0;
        pix_x     = '0;
        pix_y     = '0;
        pix_color = '0;
`ifdef FB_CLEAR_EN
        clear_req   = 1'b0;
        clear_color = '0;
`endif
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_val("rst_addr",  32'(gpu_addr),  32'd0);
        check_val("rst_data",  32'(gpu_data),  32'd0);
        check_val("rst_write", 32'(gpu_write), 32'd0);
        check_val("rst_read",  32'(gpu_read),  32'd0);
        check_val("rst_drop",  32'(drop_cnt),  32'd0);
        check_val("rst_empty", 32'(empty),     32'd1);
        check_val("rst_full",  32'(full),      32'd0);
        check_val("rst_ready", 32'(pix_ready), 32'd1);
`ifdef FB_CLEAR_EN
        check_val("rst_busy",  32'(clear_busy), 32'd0);
`endif

        // Single pixel: write appears one edge after acceptance
        push_pix(10'd5, 10'd2, 16'hFFFF);
        check_val("single_empty_n", 32'(empty),     32'd0);
        check_val("single_wr_early", 32'(gpu_write), 32'd0);
        tick();
        check_val("single_write", 32'(gpu_write), 32'd1);
        check_val("single_addr",  32'(gpu_addr),  32'd1285);
        check_val("single_data",  32'(gpu_data),  32'hFFFF);
        check_val("single_empty", 32'(empty),     32'd1);
        tick();
        check_val("single_pulse", 32'(gpu_write), 32'd0);
        check_val("single_hold",  32'(gpu_addr),  32'd1285);

        // Fill during video-on, then drain in blanking
        video_on = 1'b1;
        base = wr_n;
        for (int i = 0; i < 16; i++) begin
            push_pix(10'(i), 10'd1, 16'(16'h0A00 + i));
        end
        check_val("fill_full",  32'(full),      32'd1);
        check_val("fill_ready", 32'(pix_ready), 32'd0);
        push_pix(10'd0, 10'd0, 16'h5555);
        check_val("fill_nowr",  32'(wr_n - base), 32'd0);
        check_val("fill_drop",  32'(drop_cnt),    32'd0);
        video_on = 1'b0;
        repeat (20) tick();
        check_val("drain_cnt", 32'(wr_n - base), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check_val("drain_addr", 32'(log_addr[base+i]), 32'(640 + i));
            check_val("drain_data", 32'(log_data[base+i]), 32'(16'h0A00 + i));
        end
        check_val("drain_b2b", 32'(log_cyc[base+15] - log_cyc[base]), 32'd15);
        check_val("drain_empty", 32'(empty), 32'd1);

        // Range check and the maximum address
        base = wr_n;
        push_pix(10'd640, 10'd0, 16'h1111);
        push_pix(10'd0, 10'd400, 16'h2222);
        repeat (3) tick();
        check_val("oor_nowr",  32'(wr_n - base), 32'd0);
        check_val("oor_drop",  32'(drop_cnt),    32'd2);
        check_val("oor_empty", 32'(empty),       32'd1);
        push_pix(10'd639, 10'd399, 16'h1234);
        tick();
        check_val("max_write", 32'(gpu_write), 32'd1);
        check_val("max_addr",  32'(gpu_addr),  32'd255999);
        check_val("max_data",  32'(gpu_data),  32'h1234);
        tick();

        // Video-on interrupting a drain
        video_on = 1'b1;
        base = wr_n;
        for (int i = 0; i < 8; i++) begin
            push_pix(10'(i + 10), 10'd3, 16'(16'hB000 + i));
        end
        video_on = 1'b0;
        tick();
        tick();
        tick();
        check_val("pause_last_wr",   32'(gpu_write), 32'd1);
        check_val("pause_last_addr", 32'(gpu_addr),  32'(3*640 + 12));
        video_on = 1'b1;
        tick();
        check_val("pause_stop",  32'(gpu_write),   32'd0);
        check_val("pause_cnt",   32'(wr_n - base), 32'd3);
        check_val("pause_empty", 32'(empty),       32'd0);
        repeat (4) tick();
        check_val("pause_hold",  32'(wr_n - base), 32'd3);
        video_on = 1'b0;
        repeat (10) tick();
        check_val("resume_cnt", 32'(wr_n - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check_val("resume_addr", 32'(log_addr[base+i]), 32'(3*640 + 10 + i));
        end

`ifdef FB_CLEAR_EN
        // Queued pixels drain before the fill begins
        video_on = 1'b1;
        base = wr_n;
        for (int i = 0; i < 4; i++) begin
            push_pix(10'(i), 10'd7, 16'(16'hC000 + i));
        end
        clear_req   = 1'b1;
        clear_color = 16'h00FF;
        tick();
        clear_req = 1'b0;
        check_val("clr_busy_pend", 32'(clear_busy), 32'd1);
        video_on = 1'b0;
        repeat (12) tick();
        check_val("clr_ready", 32'(pix_ready), 32'd0);
        check_val("clr_busy",  32'(clear_busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_val("clr_pix_addr", 32'(log_addr[base+i]), 32'(7*640 + i));
        end
        for (int i = 4; i < 7; i++) begin
            check_val("clr_fill_addr", 32'(log_addr[base+i]), 32'(i - 4));
            check_val("clr_fill_data", 32'(log_data[base+i]), 32'h00FF);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("clr_rst_write", 32'(gpu_write),  32'd0);
        check_val("clr_rst_busy",  32'(clear_busy), 32'd0);
        check_val("clr_rst_empty", 32'(empty),      32'd1);
        check_val("clr_rst_drop",  32'(drop_cnt),   32'd0);
        check_val("clr_rst_ready", 32'(pix_ready),  32'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fb_write_queue.md
# fb_write_queue

Pixel write queue sitting directly downstream of the GPU draw engine and upstream of the SRAM port. Accepts (x, y, colour) pixel writes through a valid/ready handshake, converts each to a linear framebuffer address (y·640 + x), buffers it, and drains the buffer to SRAM only while video is off. This decouples rasterisation from display timing and stops draws from contending with scan-out.

## Interface
- DEPTH, 16: FIFO entries, power of two, at least 2.
- FB_WIDTH, 640: pixels per row.
- FB_HEIGHT, 400: rows.
- I_CLK  in  1: clock.
- I_RST  in  1: reset, synchronous, active-high.
- I_VIDEO_ON  in  1: display scan-out active; SRAM writes forbidden while high.
- I_PIX_VALID  in  1: pixel request valid.
- O_PIX_READY  out  1: queue can accept a pixel.
- I_PIX_X  in  10: column.
- I_PIX_Y  in  10: row.
- I_PIX_COLOR  in  16: 4:4:4:4 colour word.
- O_GPU_ADDR  out  18: SRAM address.
- O_GPU_DATA  out  16: SRAM write data.
- O_GPU_WRITE  out  1: SRAM write strobe, one cycle per word.
- O_GPU_READ  out  1: tied to 0.
- O_EMPTY  out  1: FIFO empty.
- O_FULL  out  1: FIFO full.
- O_DROP_CNT  out  16: count of out-of-range pixels, saturating.
- I_CLEAR_REQ  in  1: start a full-screen fill. Present only with FB_CLEAR_EN.
- I_CLEAR_COLOR  in  16: fill colour, sampled with I_CLEAR_REQ. Present only with FB_CLEAR_EN.
- O_CLEAR_BUSY  out  1: fill in progress. Present only with FB_CLEAR_EN.

## Operation
- Handshake: a pixel is accepted on a rising edge where I_PIX_VALID and O_PIX_READY are both high.
  - O_PIX_READY = !O_FULL && state != CLEAR.
  - There is no bypass: a pop in the same cycle never frees a slot for that cycle's push.
- Range check at acceptance:
  - x ≥ FB_WIDTH or y ≥ FB_HEIGHT: the pixel is consumed but not enqueued, and O_DROP_CNT increments, saturating at 0xFFFF.
- Address computation: (y<<9) + (y<<7) + x, 18 bits, computed combinationally at the FIFO write port. Maximum address is 255999.
- FSM states and transitions:
  - IDLE → DRAIN when !I_VIDEO_ON && !O_EMPTY.
  - DRAIN → IDLE when I_VIDEO_ON, or when the last entry pops.
  - IDLE → CLEAR when a clear is pending && O_EMPTY (FB_CLEAR_EN only).
  - CLEAR → IDLE after address 255999 is written.
- DRAIN: one entry pops per cycle. O_GPU_ADDR and O_GPU_DATA are loaded from the FIFO head, and O_GPU_WRITE=1 on the following cycle.
- Simultaneous push and pop while non-full: both occur, and occupancy is unchanged.
- Writes stop whenever I_VIDEO_ON is sampled high. The queued entry stays at the head and is issued at the next blanking interval, so no entry is lost.
- Outputs are registered. When O_GPU_WRITE=0, O_GPU_ADDR and O_GPU_DATA hold their last values.
- Reset: FIFO flushed, state=IDLE, pending clear discarded.
  - Outputs after reset: O_GPU_ADDR=0, O_GPU_DATA=0, O_GPU_WRITE=0, O_GPU_READ=0, O_DROP_CNT=0, O_EMPTY=1, O_FULL=0, O_PIX_READY=1, O_CLEAR_BUSY=0.
  - A reset mid-drain or mid-clear abandons the operation immediately.

## Timing
- Accept at edge N → O_GPU_WRITE high after edge N+1, provided the FIFO was empty and I_VIDEO_ON was low at N+1.
- Sustained throughput during blanking: one SRAM write per cycle.
- I_VIDEO_ON rising is sampled at edge M: the last write pulse is the one launched at edge M−1, and O_GPU_WRITE=0 after edge M.
- O_FULL and O_EMPTY are registered and reflect occupancy after each edge.

## Configuration
- FB_CLEAR_EN defined:
  - The CLEAR state and the three clear ports exist.
  - An I_CLEAR_REQ pulse latches I_CLEAR_COLOR and sets a pending flag. Requests arriving while busy or pending are ignored.
  - CLEAR starts only once the FIFO is empty. It writes addresses 0..255999 sequentially at one per blanking cycle, pauses while I_VIDEO_ON is high, and resumes at the paused address.
  - O_CLEAR_BUSY is high from the pending flag being set until the final write.
- FB_CLEAR_EN undefined: the clear ports are absent, the CLEAR state does not exist, and O_PIX_READY = !O_FULL.

## Structure
- Package fb_pkg holds:
  - FB_WIDTH, FB_HEIGHT, FB_ADDR_W=18, FB_LAST_ADDR=255999.
  - The colour_t 16-bit typedef.
  - The state enum {IDLE, DRAIN, CLEAR}.
- Sub-module fb_sync_fifo is a parameterised DEPTH×34-bit (18-bit address + 16-bit colour) synchronous FIFO with full and empty flags. fb_write_queue owns the FSM, address math, drop counter and clear sequencer.

## Test plan
- Reset, then push (x=5, y=2, 0xFFFF) with I_VIDEO_ON=0 → one O_GPU_WRITE pulse one cycle later, O_GPU_ADDR=1285, O_GPU_DATA=0xFFFF, O_EMPTY=1 afterwards.
- Hold I_VIDEO_ON=1 and push 16 pixels → O_FULL=1, O_PIX_READY=0, no writes. Drop I_VIDEO_ON → 16 consecutive write pulses in push order.
- Push (x=640, y=0) and (x=0, y=400) → no writes, O_DROP_CNT=2. Push (639, 399) → write to address 255999.
- Raise I_VIDEO_ON mid-drain after 3 of 8 writes → writes stop after the edge that samples it. Drop I_VIDEO_ON → the remaining 5 are written, and 8 unique addresses appear in total.
- FB_CLEAR_EN: queue 4 pixels, then I_CLEAR_REQ with colour 0x00FF → the 4 pixel writes issue first, then 256000 writes of 0x00FF at ascending addresses, O_PIX_READY=0 throughout, O_CLEAR_BUSY falls after address 255999.
- Assert I_RST mid-clear → next cycle O_GPU_WRITE=0, O_CLEAR_BUSY=0, O_EMPTY=1, O_DROP_CNT=0.
